// File: rtl/sar_pkg.sv
// Shared definitions for the SAR ADC controller: FSM state encoding and
// default geometry of the external DAC shift register.
package sar_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_SHIFT,
    ST_LATCH,
    ST_SETTLE,
    ST_COMPARE,
    ST_DONE
  } sar_state_t;

  localparam int SR_WIDTH_DEF = 16;
  localparam int SCLK_DIV_DEF = 2;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sar_adc_ctrl_if.sv
// Application-side conversion interface of the SAR ADC controller.
interface sar_adc_ctrl_if #(
  parameter int RES_BITS = 14
);
  // start_i is a request sampled every cycle; it is accepted only while busy_o
  // is low (controller idle) and is otherwise dropped, never queued. busy_o
  // stays high until the done_o cycle inclusive; result_o is valid from the
  // done_o cycle and holds until the next done_o.
  logic                start_i;
  logic                busy_o;
  logic                done_o;
  logic [RES_BITS-1:0] result_o;

  modport master (output start_i, input busy_o, input done_o, input result_o);
  modport slave  (input start_i, output busy_o, output done_o, output result_o);

endinterface

// File: rtl/shreg_serializer.sv
// Serialises a word MSB first into an external shift register (SClk) and then
// pulses its latch clock (LClk). All pin outputs come straight from flops.
module shreg_serializer #(
  parameter int SR_WIDTH = 16,
  parameter int SCLK_DIV = 2
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                load_i,
  input  logic [SR_WIDTH-1:0] word_i,
  output logic                ser_o,
  output logic                sclk_o,
  output logic                lclk_o,
  output logic                shift_done_o,
  output logic                ready_o
);

  localparam int CW  = $clog2(2 * SCLK_DIV);
  localparam int BCW = (SR_WIDTH > 1) ? $clog2(SR_WIDTH) : 1;

  logic [SR_WIDTH-1:0] sr_q;
  logic [CW-1:0]       cnt_q;
  logic [BCW-1:0]      bit_q;
  logic                shifting_q, latching_q;
  logic                ser_q, sclk_q, lclk_q;
  logic                half_end, bit_end, last_bit;

  assign half_end = (cnt_q == CW'(SCLK_DIV - 1));
  assign bit_end  = (cnt_q == CW'(2 * SCLK_DIV - 1));
  assign last_bit = (bit_q == BCW'(SR_WIDTH - 1));

  assign shift_done_o = shifting_q & bit_end & last_bit;
  assign ready_o      = latching_q & half_end;
  assign ser_o        = ser_q;
  assign sclk_o       = sclk_q;
  assign lclk_o       = lclk_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sr_q       <= '0;
      cnt_q      <= '0;
      bit_q      <= '0;
      shifting_q <= 1'b0;
      latching_q <= 1'b0;
      ser_q      <= 1'b0;
      sclk_q     <= 1'b0;
      lclk_q     <= 1'b0;
    end else if (load_i) begin
      sr_q       <= word_i << 1;
      ser_q      <= word_i[SR_WIDTH-1];
      cnt_q      <= '0;
      bit_q      <= '0;
      shifting_q <= 1'b1;
      latching_q <= 1'b0;
      sclk_q     <= 1'b0;
      lclk_q     <= 1'b0;
    end else if (shifting_q) begin
      // Ser only moves on the edge where SClk drops, so it is stable for the whole bit.
      if (bit_end) begin
        cnt_q  <= '0;
        sclk_q <= 1'b0;
        if (last_bit) begin
          shifting_q <= 1'b0;
          latching_q <= 1'b1;
          lclk_q     <= 1'b1;
          ser_q      <= 1'b0;
        end else begin
          bit_q <= bit_q + 1'b1;
          ser_q <= sr_q[SR_WIDTH-1];
          sr_q  <= sr_q << 1;
        end
      end else begin
        cnt_q <= cnt_q + 1'b1;
        if (half_end) sclk_q <= 1'b1;
      end
    end else if (latching_q) begin
      if (half_end) begin
        latching_q <= 1'b0;
        lclk_q     <= 1'b0;
        cnt_q      <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation conversion sequencer for the PmodADC front end.
// Owns the SAR code, bit index and timers; the serializer drives the DAC pins.
module sar_adc_ctrl
  import sar_pkg::*;
#(
  parameter int RES_BITS      = 14,
  parameter int SR_WIDTH      = SR_WIDTH_DEF,
  parameter int SCLK_DIV      = SCLK_DIV_DEF,
  parameter int SH_CYCLES     = 16,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic           clk_i,
  input  logic           reset_i,
  sar_adc_ctrl_if.slave  app,
  output logic           ADC_SH_o,
  output logic           ADC_Ser_o,
  output logic           ADC_SClk_o,
  output logic           ADC_LClk_o,
  input  logic           ADC_Comp_i,
  output sar_state_t     state_o
);

  localparam int TW  = $clog2(max2(SH_CYCLES, SETTLE_CYCLES) + 1);
  localparam int BW  = (RES_BITS > 1) ? $clog2(RES_BITS) : 1;
  localparam int PAD = SR_WIDTH - RES_BITS;

  sar_state_t          state_q, state_n;
  logic [TW-1:0]       timer_q;
  logic [BW-1:0]       idx_q, idx_n;
  logic [RES_BITS-1:0] code_q, code_n, trial_q, trial_n, result_q, result_n;
  logic [RES_BITS-1:0] cmp_code;
  logic                comp_meta_q, comp_sync_q;
  logic                busy_q, done_q, sh_q;
  logic                ser_load, ser_shift_done, ser_ready;
  logic [SR_WIDTH-1:0] ser_word;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      idx_q       <= '0;
      code_q      <= '0;
      trial_q     <= '0;
      result_q    <= '0;
      comp_meta_q <= 1'b0;
      comp_sync_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sh_q        <= 1'b0;
    end else begin
      state_q     <= state_n;
      // Timer restarts on every state change, so SAMPLE/SETTLE count from zero.
      timer_q     <= (state_n != state_q) ? '0 : timer_q + 1'b1;
      idx_q       <= idx_n;
      code_q      <= code_n;
      trial_q     <= trial_n;
      result_q    <= result_n;
      comp_meta_q <= ADC_Comp_i;
      comp_sync_q <= comp_meta_q;
      busy_q      <= (state_n != ST_IDLE);
      done_q      <= (state_n == ST_DONE);
      sh_q        <= (state_n == ST_SAMPLE);
    end
  end

  assign cmp_code = comp_sync_q ? trial_q : code_q;

  always_comb begin
    state_n  = state_q;
    idx_n    = idx_q;
    code_n   = code_q;
    trial_n  = trial_q;
    result_n = result_q;
    ser_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (app.start_i) begin
          state_n = ST_SAMPLE;
          code_n  = '0;
          idx_n   = BW'(RES_BITS - 1);
        end
      end
      ST_SAMPLE: begin
        if (timer_q == TW'(SH_CYCLES - 1)) begin
          state_n  = ST_SHIFT;
          trial_n  = code_q | (RES_BITS'(1) << idx_q);
          ser_load = 1'b1;
        end
      end
      ST_SHIFT:  if (ser_shift_done) state_n = ST_LATCH;
      ST_LATCH:  if (ser_ready) state_n = ST_SETTLE;
      ST_SETTLE: if (timer_q == TW'(SETTLE_CYCLES - 1)) state_n = ST_COMPARE;
      ST_COMPARE: begin
        code_n = cmp_code;
        if (idx_q == '0) begin
          state_n  = ST_DONE;
          result_n = cmp_code;
        end else begin
          // Next trial is built from the freshly decided code.
          state_n  = ST_SHIFT;
          idx_n    = idx_q - 1'b1;
          trial_n  = cmp_code | (RES_BITS'(1) << (idx_q - 1'b1));
          ser_load = 1'b1;
        end
      end
      ST_DONE:   state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  assign ser_word = SR_WIDTH'(trial_n) << PAD;

  shreg_serializer #(
    .SR_WIDTH (SR_WIDTH),
    .SCLK_DIV (SCLK_DIV)
  ) u_ser (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .load_i       (ser_load),
    .word_i       (ser_word),
    .ser_o        (ADC_Ser_o),
    .sclk_o       (ADC_SClk_o),
    .lclk_o       (ADC_LClk_o),
    .shift_done_o (ser_shift_done),
    .ready_o      (ser_ready)
  );

  assign app.busy_o   = busy_q;
  assign app.done_o   = done_q;
  assign app.result_o = result_q;
  assign ADC_SH_o     = sh_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Bench for sar_adc_ctrl: models the external DAC shift register/latch and the
// comparator, and checks results and latched trial words against a SAR model.
module tb_sar_adc_ctrl;
  import sar_pkg::*;

  localparam int RES_BITS      = 14;
  localparam int SR_WIDTH      = 16;
  localparam int SCLK_DIV      = 2;
  localparam int SH_CYCLES     = 16;
  localparam int SETTLE_CYCLES = 8;
  localparam int LATENCY = SH_CYCLES
                         + RES_BITS * (2 * SCLK_DIV * SR_WIDTH + SCLK_DIV + SETTLE_CYCLES + 1) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sar_adc_ctrl_if #(.RES_BITS(RES_BITS)) app_if ();
  logic       adc_sh, adc_ser, adc_sclk, adc_lclk, adc_comp;
  sar_state_t state_dbg;

  sar_adc_ctrl #(
    .RES_BITS(RES_BITS), .SR_WIDTH(SR_WIDTH), .SCLK_DIV(SCLK_DIV),
    .SH_CYCLES(SH_CYCLES), .SETTLE_CYCLES(SETTLE_CYCLES)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .app        (app_if),
    .ADC_SH_o   (adc_sh),
    .ADC_Ser_o  (adc_ser),
    .ADC_SClk_o (adc_sclk),
    .ADC_LClk_o (adc_lclk),
    .ADC_Comp_i (adc_comp),
    .state_o    (state_dbg)
  );

  int n_cmp = 0;
  int n_err = 0;
  int mon_err = 0;
  bit mon_en = 1'b0;

  // ---------------- external ADC front-end model ----------------
  logic [15:0] adc_val = '0;
  logic [15:0] sr_model = '0;
  logic [15:0] latched_word = '0;
  logic [15:0] obs_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] last_obs[$];

  assign adc_comp = (latched_word <= adc_val);

  always @(posedge adc_sclk) sr_model <= {sr_model[14:0], adc_ser};
  always @(posedge adc_lclk) begin
    latched_word = sr_model;
    obs_q.push_back(sr_model);
  end

  // ---------------- pin-level checks every cycle ----------------
  logic prev_ser = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      n_cmp++;
      if (adc_sclk && adc_lclk) begin
        n_err++; mon_err++;
        if (mon_err < 6) $display("FAIL sclk_lclk_overlap: got sclk=%b lclk=%b, expected not both 1", adc_sclk, adc_lclk);
      end
      if (adc_ser !== prev_ser) begin
        n_cmp++;
        if (adc_sclk !== 1'b0) begin
          n_err++; mon_err++;
          if (mon_err < 6) $display("FAIL ser_change_sclk_high: got sclk=%b at ser change, expected 0", adc_sclk);
        end
      end
      if (state_dbg inside {ST_SHIFT, ST_LATCH, ST_SETTLE, ST_COMPARE, ST_DONE}) begin
        n_cmp++;
        if (adc_sh !== 1'b0) begin
          n_err++; mon_err++;
          if (mon_err < 6) $display("FAIL sh_hold: got SH=%b in %s, expected 0", adc_sh, state_dbg.name());
        end
      end
      if (!(state_dbg inside {ST_SHIFT, ST_LATCH})) begin
        n_cmp++;
        if ({adc_ser, adc_sclk, adc_lclk} !== 3'b000) begin
          n_err++; mon_err++;
          if (mon_err < 6) $display("FAIL pins_quiet: got ser/sclk/lclk=%b in %s, expected 000",
                                    {adc_ser, adc_sclk, adc_lclk}, state_dbg.name());
        end
      end
    end
    prev_ser = adc_ser;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural SAR: try each bit from the MSB, keep it if the DAC word <= input.
  task automatic model_conv(input logic [15:0] v, output logic [13:0] res);
    logic [13:0] code;
    logic [13:0] trial;
    logic [15:0] word;
    code = '0;
    for (int n = RES_BITS - 1; n >= 0; n--) begin
      trial = code | (14'd1 << n);
      word  = {trial, 2'b00};
      exp_q.push_back(word);
      if (word <= v) code = trial;
    end
    res = code;
  endtask

  task automatic check_words(input string tag);
    logic [15:0] o, e;
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL %s word_count: got %0d, expected %0d", tag, obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s latched_word: got %h, expected %h", tag, o, e);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic run_conversion(input string tag, input logic [15:0] v);
    logic [13:0] exp_res;
    int cyc;
    adc_val = v;
    obs_q.delete();
    exp_q.delete();
    model_conv(v, exp_res);
    n_cmp++;
    if (app_if.busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL %s busy_before: got %b, expected 0", tag, app_if.busy_o);
    end
    app_if.start_i = 1'b1;
    step();
    app_if.start_i = 1'b0;
    cyc = 1;
    while (app_if.done_o !== 1'b1 && cyc < 3000) begin
      step();
      cyc++;
    end
    n_cmp++;
    if (cyc != LATENCY) begin
      n_err++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", tag, cyc, LATENCY);
    end
    n_cmp++;
    if (app_if.result_o !== exp_res) begin
      n_err++;
      $display("FAIL %s result: got %h, expected %h", tag, app_if.result_o, exp_res);
    end
    n_cmp++;
    if (app_if.busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL %s busy_at_done: got %b, expected 1", tag, app_if.busy_o);
    end
    last_obs = obs_q;
    check_words(tag);
    step();
    n_cmp++;
    if ({app_if.done_o, app_if.busy_o} !== 2'b00) begin
      n_err++;
      $display("FAIL %s after_done: got done/busy=%b, expected 00", tag, {app_if.done_o, app_if.busy_o});
    end
    n_cmp++;
    if (app_if.result_o !== exp_res) begin
      n_err++;
      $display("FAIL %s result_hold: got %h, expected %h", tag, app_if.result_o, exp_res);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    app_if.start_i = 1'b0;
    repeat (3) step();
    n_cmp++;
    if ({app_if.busy_o, app_if.done_o, adc_sh, adc_ser, adc_sclk, adc_lclk} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b, expected 000000",
               {app_if.busy_o, app_if.done_o, adc_sh, adc_ser, adc_sclk, adc_lclk});
    end
    n_cmp++;
    if (app_if.result_o !== '0) begin
      n_err++;
      $display("FAIL reset_result: got %h, expected 0", app_if.result_o);
    end
    n_cmp++;
    if (state_dbg !== ST_IDLE) begin
      n_err++;
      $display("FAIL reset_state: got %s, expected ST_IDLE", state_dbg.name());
    end
    reset = 1'b0;
    step();
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    run_conversion("conv_2a52", 16'h2A52);
  endtask

  task automatic test_latched_words();
    logic [15:0] exp_first[3];
    exp_first[0] = 16'h8000;
    exp_first[1] = 16'h4000;
    exp_first[2] = 16'h2000;
    n_cmp++;
    if (last_obs.size() < 3) begin
      n_err++;
      $display("FAIL first_words_count: got %0d, expected >=3", last_obs.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (last_obs[i] !== exp_first[i]) begin
          n_err++;
          $display("FAIL first_words[%0d]: got %h, expected %h", i, last_obs[i], exp_first[i]);
        end
      end
    end
  endtask

  task automatic test_extremes();
    run_conversion("conv_0000", 16'h0000);
    run_conversion("conv_ffff", 16'hFFFF);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) run_conversion("conv_rand", 16'($urandom_range(0, 16'hFFFF)));
  endtask

  task automatic test_back_to_back();
    logic [13:0] exp_res;
    int cyc, idle_cnt;
    adc_val = 16'($urandom_range(0, 16'hFFFF));
    obs_q.delete();
    exp_q.delete();
    model_conv(adc_val, exp_res);
    model_conv(adc_val, exp_res);
    app_if.start_i = 1'b1;
    cyc = 0;
    do begin step(); cyc++; end while (app_if.done_o !== 1'b1 && cyc < 3000);
    n_cmp++;
    if (cyc != LATENCY) begin
      n_err++;
      $display("FAIL b2b first_latency: got %0d, expected %0d", cyc, LATENCY);
    end
    n_cmp++;
    if (app_if.result_o !== exp_res) begin
      n_err++;
      $display("FAIL b2b first_result: got %h, expected %h", app_if.result_o, exp_res);
    end
    cyc = 0;
    idle_cnt = 0;
    do begin
      step();
      cyc++;
      if (app_if.busy_o === 1'b0) idle_cnt++;
    end while (app_if.done_o !== 1'b1 && cyc < 3000);
    app_if.start_i = 1'b0;
    n_cmp++;
    if (cyc != LATENCY + 1) begin
      n_err++;
      $display("FAIL b2b spacing: got %0d, expected %0d", cyc, LATENCY + 1);
    end
    n_cmp++;
    if (idle_cnt != 1) begin
      n_err++;
      $display("FAIL b2b idle_cycles: got %0d, expected 1", idle_cnt);
    end
    n_cmp++;
    if (app_if.result_o !== exp_res) begin
      n_err++;
      $display("FAIL b2b second_result: got %h, expected %h", app_if.result_o, exp_res);
    end
    check_words("b2b");
    step();
    step();
  endtask

  task automatic test_start_during_busy();
    logic [13:0] exp_res;
    int cyc, dones;
    adc_val = 16'($urandom_range(0, 16'hFFFF));
    obs_q.delete();
    exp_q.delete();
    model_conv(adc_val, exp_res);
    app_if.start_i = 1'b1;
    step();
    cyc = 1;
    dones = 0;
    while (cyc < 3000) begin
      if (app_if.done_o === 1'b1) begin
        dones++;
        app_if.start_i = 1'b0;
        break;
      end
      app_if.start_i = 1'($urandom_range(0, 1));
      step();
      cyc++;
    end
    n_cmp++;
    if (app_if.result_o !== exp_res) begin
      n_err++;
      $display("FAIL busy_pulses result: got %h, expected %h", app_if.result_o, exp_res);
    end
    for (int i = 0; i < 40; i++) begin
      step();
      if (app_if.done_o === 1'b1) dones++;
    end
    n_cmp++;
    if (dones != 1) begin
      n_err++;
      $display("FAIL busy_pulses done_count: got %0d, expected 1", dones);
    end
    check_words("busy_pulses");
  endtask

  task automatic test_reset_mid();
    int cyc, dones;
    adc_val = 16'($urandom_range(0, 16'hFFFF));
    obs_q.delete();
    app_if.start_i = 1'b1;
    step();
    app_if.start_i = 1'b0;
    cyc = 0;
    while (!(obs_q.size() == 6 && state_dbg == ST_SHIFT) && cyc < 3000) begin
      step();
      cyc++;
    end
    n_cmp++;
    if (cyc >= 3000) begin
      n_err++;
      $display("FAIL reset_mid reach_bit7: got timeout after %0d cycles, expected SHIFT of bit 7", cyc);
    end
    repeat ($urandom_range(0, 20)) step();
    reset = 1'b1;
    step();
    n_cmp++;
    if ({app_if.busy_o, app_if.done_o, adc_sh, adc_ser, adc_sclk, adc_lclk} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_mid outputs: got %b, expected 000000",
               {app_if.busy_o, app_if.done_o, adc_sh, adc_ser, adc_sclk, adc_lclk});
    end
    n_cmp++;
    if (state_dbg !== ST_IDLE) begin
      n_err++;
      $display("FAIL reset_mid state: got %s, expected ST_IDLE", state_dbg.name());
    end
    reset = 1'b0;
    dones = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (app_if.done_o === 1'b1) dones++;
    end
    n_cmp++;
    if (dones != 0) begin
      n_err++;
      $display("FAIL reset_mid spurious_done: got %0d, expected 0", dones);
    end
    run_conversion("after_reset", 16'($urandom_range(0, 16'hFFFF)));
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    app_if.start_i = 1'b0;
    test_reset();
    test_basic();
    test_latched_words();
    test_extremes();
    test_random();
    test_back_to_back();
    test_start_during_busy();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout at %0t, expected bench completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
